// File: rtl/multicycle_controller_if.sv
// Control bundle between the multi-cycle controller and the datapath.
// master = controller side, slave = datapath side.
interface multicycle_controller_if;
  logic [6:0] op;
  logic       zero;
  logic       mem_ready;
  logic       PCWrite;
  logic       AdrSrc;
  logic       IRWrite;
  logic       MemWrite;
  logic       RegWrite;
  logic [1:0] ResultSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ALUOp;
  logic [1:0] ImmSrc;
  logic       instr_done;
  logic       illegal;

  modport master (
    input  op, zero, mem_ready,
    output PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite, ResultSrc,
           ALUSrcA, ALUSrcB, ALUOp, ImmSrc, instr_done, illegal
  );
  modport slave (
    output op, zero, mem_ready,
    input  PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite, ResultSrc,
           ALUSrcA, ALUSrcB, ALUOp, ImmSrc, instr_done, illegal
  );
endinterface

// File: rtl/multicycle_controller.sv
// Multi-cycle RISC-V control FSM: one state per cycle, Moore selects plus
// mem_ready/zero gated strobes. Define MC_CTRL_IMM_EN to add I-type ALU and jal.
module multicycle_controller (
  input  logic                           clk,
  input  logic                           rst_n,
  multicycle_controller_if.master        ctl
);
  localparam logic [3:0] FETCH    = 4'd0;
  localparam logic [3:0] DECODE   = 4'd1;
  localparam logic [3:0] MEMADR   = 4'd2;
  localparam logic [3:0] MEMREAD  = 4'd3;
  localparam logic [3:0] MEMWB    = 4'd4;
  localparam logic [3:0] MEMWRITE = 4'd5;
  localparam logic [3:0] EXECUTER = 4'd6;
  localparam logic [3:0] ALUWB    = 4'd7;
  localparam logic [3:0] BEQ      = 4'd8;
`ifdef MC_CTRL_IMM_EN
  localparam logic [3:0] EXECUTEI = 4'd9;
  localparam logic [3:0] JAL      = 4'd10;
`endif

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  logic [3:0] state, nextState;
  logic       pcw, irw, mw, rw, done, ill;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FETCH;
    else        state <= nextState;
  end

  always_comb begin
    nextState     = FETCH;
    pcw           = 1'b0;
    irw           = 1'b0;
    mw            = 1'b0;
    rw            = 1'b0;
    done          = 1'b0;
    ill           = 1'b0;
    ctl.AdrSrc    = 1'b0;
    ctl.ResultSrc = 2'b00;
    ctl.ALUSrcA   = 2'b00;
    ctl.ALUSrcB   = 2'b00;
    ctl.ALUOp     = 2'b00;
    case (state)
      FETCH: begin
        ctl.ALUSrcB   = 2'b10;
        ctl.ResultSrc = 2'b10;
        irw           = ctl.mem_ready;
        pcw           = ctl.mem_ready;
        nextState     = ctl.mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        ctl.ALUSrcA = 2'b01;
        ctl.ALUSrcB = 2'b01;
        case (ctl.op)
          OP_LW, OP_SW: nextState = MEMADR;
          OP_R:         nextState = EXECUTER;
          OP_BEQ:       nextState = BEQ;
`ifdef MC_CTRL_IMM_EN
          OP_IMM:       nextState = EXECUTEI;
          OP_JAL:       nextState = JAL;
`endif
          default:      ill = 1'b1;
        endcase
      end
      MEMADR: begin
        ctl.ALUSrcA = 2'b10;
        ctl.ALUSrcB = 2'b01;
        nextState   = (ctl.op == OP_SW) ? MEMWRITE : MEMREAD;
      end
      MEMREAD: begin
        ctl.AdrSrc = 1'b1;
        nextState  = ctl.mem_ready ? MEMWB : MEMREAD;
      end
      MEMWB: begin
        ctl.ResultSrc = 2'b01;
        rw            = 1'b1;
        done          = 1'b1;
      end
      MEMWRITE: begin
        ctl.AdrSrc = 1'b1;
        mw         = 1'b1;
        done       = ctl.mem_ready;
        nextState  = ctl.mem_ready ? FETCH : MEMWRITE;
      end
      EXECUTER: begin
        ctl.ALUSrcA = 2'b10;
        ctl.ALUOp   = 2'b10;
        nextState   = ALUWB;
      end
      ALUWB: begin
        rw   = 1'b1;
        done = 1'b1;
      end
      BEQ: begin
        ctl.ALUSrcA = 2'b10;
        ctl.ALUOp   = 2'b01;
        pcw         = ctl.zero;
        done        = 1'b1;
      end
`ifdef MC_CTRL_IMM_EN
      EXECUTEI: begin
        ctl.ALUSrcA = 2'b10;
        ctl.ALUSrcB = 2'b01;
        ctl.ALUOp   = 2'b10;
        nextState   = ALUWB;
      end
      JAL: begin
        ctl.ALUSrcA = 2'b01;
        ctl.ALUSrcB = 2'b10;
        pcw         = 1'b1;
        nextState   = ALUWB;
      end
`endif
      default: nextState = FETCH;
    endcase
  end

  // Strobes are forced low while reset is held so nothing leaks from FETCH.
  assign ctl.PCWrite    = pcw  & rst_n;
  assign ctl.IRWrite    = irw  & rst_n;
  assign ctl.MemWrite   = mw   & rst_n;
  assign ctl.RegWrite   = rw   & rst_n;
  assign ctl.instr_done = done & rst_n;
  assign ctl.illegal    = ill  & rst_n;

  always_comb begin
    case (ctl.op)
      OP_SW:   ctl.ImmSrc = 2'b01;
      OP_BEQ:  ctl.ImmSrc = 2'b10;
      OP_JAL:  ctl.ImmSrc = 2'b11;
      default: ctl.ImmSrc = 2'b00;
    endcase
  end
endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: vector table, hand sequences for waits and
// reset, then random instruction streams expanded by an instruction-level model.
module tb_multicycle_controller;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  multicycle_controller_if bus ();
  multicycle_controller dut (.clk(clk), .rst_n(rst_n), .ctl(bus));

  typedef struct packed {
    logic       pcw, adr, irw, mw, rw;
    logic [1:0] rs, asa, asb, aop, imm;
    logic       done, ill;
  } ctl_t;

  typedef struct {
    logic       rn;
    logic [6:0] op;
    logic       z, mr;
    ctl_t       exp;
    string      name;
  } vec_t;

  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
  localparam logic [6:0] BQ = 7'b1100011, IM = 7'b0010011, JL = 7'b1101111;

  // Phases of an instruction, named after the cycle they describe.
  localparam int P_RST = 0, P_F = 1, P_D = 2, P_MA = 3, P_MR = 4, P_MWB = 5;
  localparam int P_MW = 6, P_EXR = 7, P_AWB = 8, P_BEQ = 9, P_EXI = 10, P_JAL = 11;

  int checks = 0;
  int failures = 0;
  vec_t tbl[$];
  vec_t scb[$];

  function automatic logic [1:0] immOf(logic [6:0] o);
    return (o == SW) ? 2'b01 : (o == BQ) ? 2'b10 : (o == JL) ? 2'b11 : 2'b00;
  endfunction

  function automatic bit legal(logic [6:0] o);
    bit l = (o == LW) || (o == SW) || (o == RT) || (o == BQ);
`ifdef MC_CTRL_IMM_EN
    l = l || (o == IM) || (o == JL);
`endif
    return l;
  endfunction

  function automatic ctl_t ph(int p, logic [6:0] o, logic z, logic m);
    ctl_t c = '0;
    c.imm = immOf(o);
    case (p)
      P_RST: begin c.asb = 2'b10; c.rs = 2'b10; end
      P_F:   begin c.asb = 2'b10; c.rs = 2'b10; c.irw = m; c.pcw = m; end
      P_D:   begin c.asa = 2'b01; c.asb = 2'b01; c.ill = !legal(o); end
      P_MA:  begin c.asa = 2'b10; c.asb = 2'b01; end
      P_MR:  c.adr = 1'b1;
      P_MWB: begin c.rs = 2'b01; c.rw = 1'b1; c.done = 1'b1; end
      P_MW:  begin c.adr = 1'b1; c.mw = 1'b1; c.done = m; end
      P_EXR: begin c.asa = 2'b10; c.aop = 2'b10; end
      P_AWB: begin c.rw = 1'b1; c.done = 1'b1; end
      P_BEQ: begin c.asa = 2'b10; c.aop = 2'b01; c.pcw = z; c.done = 1'b1; end
      P_EXI: begin c.asa = 2'b10; c.asb = 2'b01; c.aop = 2'b10; end
      P_JAL: begin c.asa = 2'b01; c.asb = 2'b10; c.pcw = 1'b1; end
      default: c = 'x;
    endcase
    return c;
  endfunction

  function automatic void add(logic rn, logic [6:0] o, logic z, logic m, int p, string nm);
    vec_t v;
    v.rn = rn; v.op = o; v.z = z; v.mr = m; v.exp = ph(p, o, z, m); v.name = nm;
    tbl.push_back(v);
  endfunction

  // Instruction-level model: an opcode expands into its phase list, with
  // random memory stalls repeating the FETCH / MEMREAD / MEMWRITE phase.
  function automatic void addWait(int p, logic [6:0] o, logic z, string nm);
    logic m;
    do begin
      vec_t v;
      m = ($urandom_range(0, 9) < 7);
      v.rn = 1'b1; v.op = o; v.z = z; v.mr = m; v.exp = ph(p, o, z, m); v.name = nm;
      scb.push_back(v);
    end while (!m);
  endfunction

  function automatic void expand(logic [6:0] o, logic z);
    int body[$];
    vec_t v;
    addWait(P_F, o, z, "rnd_fetch");
    v.rn = 1'b1; v.op = o; v.z = z; v.mr = $urandom_range(0, 1);
    v.exp = ph(P_D, o, z, v.mr); v.name = "rnd_decode";
    scb.push_back(v);
    if (!legal(o)) return;
    case (o)
      LW: begin body = '{P_MA}; end
      SW: begin body = '{P_MA}; end
      RT: body = '{P_EXR, P_AWB};
      BQ: body = '{P_BEQ};
      IM: body = '{P_EXI, P_AWB};
      default: body = '{P_JAL, P_AWB};
    endcase
    foreach (body[i]) begin
      v.mr = $urandom_range(0, 1); v.exp = ph(body[i], o, z, v.mr); v.name = "rnd_body";
      scb.push_back(v);
    end
    if (o == LW) begin
      addWait(P_MR, o, z, "rnd_memread");
      v.mr = $urandom_range(0, 1); v.exp = ph(P_MWB, o, z, v.mr); v.name = "rnd_memwb";
      scb.push_back(v);
    end
    if (o == SW) addWait(P_MW, o, z, "rnd_memwrite");
  endfunction

  task automatic step(input vec_t v);
    ctl_t got;
    rst_n = v.rn; bus.op = v.op; bus.zero = v.z; bus.mem_ready = v.mr;
    @(negedge clk);
    got = '{bus.PCWrite, bus.AdrSrc, bus.IRWrite, bus.MemWrite, bus.RegWrite,
            bus.ResultSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp, bus.ImmSrc,
            bus.instr_done, bus.illegal};
    checks++;
    if (got !== v.exp) begin
      failures++;
      $display("FAIL %s op=%b got=%h exp=%h", v.name, v.op, got, v.exp);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    logic [6:0] pool[7];
    logic [6:0] o;
    rst_n = 1'b0; bus.op = LW; bus.zero = 1'b0; bus.mem_ready = 1'b1;
    @(posedge clk); #1;

    add(0, LW, 0, 1, P_RST, "reset0");  add(0, SW, 0, 1, P_RST, "reset1");
    add(1, LW, 0, 1, P_F, "lw_f");      add(1, LW, 0, 1, P_D, "lw_d");
    add(1, LW, 0, 1, P_MA, "lw_ma");    add(1, LW, 0, 1, P_MR, "lw_mr");
    add(1, LW, 0, 1, P_MWB, "lw_wb");
    add(1, BQ, 1, 1, P_F, "beq1_f");    add(1, BQ, 1, 1, P_D, "beq1_d");
    add(1, BQ, 1, 1, P_BEQ, "beq1_x");
    add(1, BQ, 0, 1, P_F, "beq0_f");    add(1, BQ, 0, 1, P_D, "beq0_d");
    add(1, BQ, 0, 1, P_BEQ, "beq0_x");
    add(1, RT, 0, 1, P_F, "r_f");       add(1, RT, 0, 1, P_D, "r_d");
    add(1, RT, 0, 1, P_EXR, "r_ex");    add(1, RT, 0, 1, P_AWB, "r_wb");
    add(1, IM, 0, 1, P_F, "imm_f");     add(1, IM, 0, 1, P_D, "imm_d");
`ifdef MC_CTRL_IMM_EN
    add(1, IM, 0, 1, P_EXI, "imm_ex");  add(1, IM, 0, 1, P_AWB, "imm_wb");
    add(1, JL, 0, 1, P_F, "jal_f");     add(1, JL, 0, 1, P_D, "jal_d");
    add(1, JL, 0, 1, P_JAL, "jal_x");   add(1, JL, 0, 1, P_AWB, "jal_wb");
`endif
    add(1, RT, 0, 1, P_F, "after_f");   add(1, RT, 0, 1, P_D, "after_d");
    add(1, RT, 0, 1, P_EXR, "after_ex"); add(1, RT, 0, 1, P_AWB, "after_wb");

    // sw with two memory stalls: MemWrite held three cycles, done in the last
    add(1, SW, 0, 1, P_F, "sw_f");      add(1, SW, 0, 1, P_D, "sw_d");
    add(1, SW, 0, 1, P_MA, "sw_ma");    add(1, SW, 0, 0, P_MW, "sw_w1");
    add(1, SW, 0, 0, P_MW, "sw_w2");    add(1, SW, 0, 1, P_MW, "sw_w3");

    // fetch stall, lw stalled in MEMREAD while op wanders, then reset mid-read
    add(1, LW, 0, 0, P_F, "rs_fwait");  add(1, LW, 0, 1, P_F, "rs_f");
    add(1, LW, 0, 1, P_D, "rs_d");      add(1, LW, 0, 1, P_MA, "rs_ma");
    add(1, RT, 0, 0, P_MR, "rs_mr_op");
    add(0, LW, 1, 1, P_RST, "rs_hold0"); add(0, LW, 1, 1, P_RST, "rs_hold1");
    add(0, LW, 1, 1, P_RST, "rs_hold2");
    add(1, LW, 0, 1, P_F, "rs_rel_f");  add(1, LW, 0, 1, P_D, "rs_rel_d");
    add(1, LW, 0, 1, P_MA, "rs_rel_ma"); add(1, LW, 0, 1, P_MR, "rs_rel_mr");
    add(1, LW, 0, 1, P_MWB, "rs_rel_wb");

    foreach (tbl[i]) step(tbl[i]);

    pool = '{LW, SW, RT, BQ, IM, JL, 7'b1111111};
    for (int n = 0; n < 60; n++) begin
      o = pool[$urandom_range(0, 6)];
      expand(o, 1'($urandom_range(0, 1)));
    end
    while (scb.size() > 0) step(scb.pop_front());

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Control FSM that sequences the multi-cycle RISC-V datapath: one shared ALU and one unified instruction/data memory, reused across several cycles per instruction. It sits beside the ALU decoder. It consumes the opcode latched in the instruction register, the ALU `zero` flag and a memory-ready handshake. It drives every mux select and write strobe, one state per cycle.

## Interface
Parameters:
- none

Ports:
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous, active-low reset
- `op`  in  7  opcode field from the instruction register
- `zero`  in  1  ALU zero flag
- `mem_ready`  in  1  memory completed the current access this cycle
- `PCWrite`  out  1  PC register write enable
- `AdrSrc`  out  1  memory address select: 0 = PC, 1 = ALUOut
- `IRWrite`  out  1  instruction and old-PC register write enable
- `MemWrite`  out  1  memory write strobe
- `RegWrite`  out  1  register file write enable
- `ResultSrc`  out  2  result select: 00 = ALUOut, 01 = Data, 10 = ALUResult
- `ALUSrcA`  out  2  ALU A select: 00 = PC, 01 = OldPC, 10 = rs1 register
- `ALUSrcB`  out  2  ALU B select: 00 = rs2 register, 01 = ImmExt, 10 = constant 4
- `ALUOp`  out  2  to ALU decoder: 00 = add, 01 = subtract, 10 = use funct fields
- `ImmSrc`  out  2  immediate format select
- `instr_done`  out  1  one-cycle pulse in the final cycle of each instruction
- `illegal`  out  1  one-cycle pulse when DECODE sees an unsupported opcode

## Operation
State register is 4 bits; its reset state is FETCH. Outputs not listed for a state are 0.

- **FETCH**
  - Drives `AdrSrc`=0, `ALUSrcA`=00, `ALUSrcB`=10, `ALUOp`=00, `ResultSrc`=10.
  - `IRWrite` = `PCWrite` = `mem_ready`.
  - Goes to DECODE when `mem_ready`=1; otherwise stays in FETCH.
- **DECODE**
  - Drives `ALUSrcA`=01, `ALUSrcB`=01, `ALUOp`=00 (computes the branch target).
  - Next state by opcode:
    - 0000011 or 0100011 → MEMADR
    - 0110011 → EXECUTER
    - 1100011 → BEQ
    - any other opcode → FETCH, with `illegal`=1.
- **MEMADR**
  - Drives `ALUSrcA`=10, `ALUSrcB`=01, `ALUOp`=00.
  - Goes to MEMREAD for 0000011, MEMWRITE for 0100011.
- **MEMREAD**
  - Drives `AdrSrc`=1.
  - Goes to MEMWB when `mem_ready`=1; otherwise waits.
- **MEMWB**
  - Drives `ResultSrc`=01, `RegWrite`=1, `instr_done`=1.
  - Goes to FETCH.
- **MEMWRITE**
  - Drives `AdrSrc`=1, `MemWrite`=1; `MemWrite` is held high until `mem_ready`.
  - When `mem_ready`=1: `instr_done`=1, then goes to FETCH.
- **EXECUTER**
  - Drives `ALUSrcA`=10, `ALUSrcB`=00, `ALUOp`=10.
  - Goes to ALUWB.
- **ALUWB**
  - Drives `ResultSrc`=00, `RegWrite`=1, `instr_done`=1.
  - Goes to FETCH.
- **BEQ**
  - Drives `ALUSrcA`=10, `ALUSrcB`=00, `ALUOp`=01, `ResultSrc`=00.
  - `PCWrite` = `zero`; `instr_done`=1.
  - Goes to FETCH.

Decoding rules:
- `ImmSrc` is decoded from `op` in every state: 0100011 → 01, 1100011 → 10, 1101111 → 11, all others → 00.
- Opcode is sampled only in DECODE and MEMADR. `op` changing in any other state has no effect.
- Unknown or illegal state encodings recover to FETCH on the next clock.

## Timing
- With `mem_ready` tied to 1, cycles per instruction are:
  - lw: 5
  - sw: 4
  - R-type: 4
  - beq: 3
  - I-type ALU: 4 (macro builds only)
  - jal: 4 (macro builds only)
- Each memory wait cycle adds exactly one cycle in FETCH, MEMREAD or MEMWRITE.
- Moore outputs, with three combinational terms:
  - `zero` gates `PCWrite` in BEQ.
  - `mem_ready` gates `IRWrite` and `PCWrite` in FETCH.
  - `mem_ready` gates `instr_done` in MEMWRITE.
- Reset:
  - While `rst_n`=0: state = FETCH, and `PCWrite`, `IRWrite`, `MemWrite`, `RegWrite`, `instr_done`, `illegal` are all 0.
  - Select outputs show the FETCH values (`AdrSrc`=0, `ALUSrcA`=00, `ALUSrcB`=10, `ALUOp`=00, `ResultSrc`=10, `ImmSrc` decoded from `op`).
  - Reset asserted in any state aborts the instruction immediately; no strobe survives the reset edge.
  - The first FETCH strobes can occur on the first rising edge after `rst_n` deasserts.

## Configuration
- `MC_CTRL_IMM_EN` defined:
  - DECODE sends 0010011 → EXECUTEI and 1101111 → JAL.
  - **EXECUTEI**: `ALUSrcA`=10, `ALUSrcB`=01, `ALUOp`=10; goes to ALUWB.
  - **JAL**: `ALUSrcA`=01, `ALUSrcB`=10, `ALUOp`=00, `ResultSrc`=00, `PCWrite`=1; goes to ALUWB.
- `MC_CTRL_IMM_EN` undefined: both opcodes take the `illegal` path, and the EXECUTEI and JAL states do not exist.

## Test plan
- Reset with `rst_n`=0 for 3 cycles mid-MEMREAD → all strobes 0 during reset; `IRWrite`=1 on the first cycle after release.
- lw (op=0000011), `mem_ready`=1 → states FETCH, DECODE, MEMADR, MEMREAD, MEMWB; `RegWrite`=1 with `ResultSrc`=01 in cycle 5 only; `instr_done` pulses once.
- sw with `mem_ready` low for 2 cycles in MEMWRITE → `MemWrite`=1 for 3 consecutive cycles, `instr_done` in the 3rd; total 6 cycles.
- beq with `zero`=1, then beq with `zero`=0 → `PCWrite`=1 in BEQ for the first only; each instruction takes 3 cycles.
- R-type (op=0110011) → `ALUOp`=10 in EXECUTER, `RegWrite`=1 in ALUWB; 4 cycles.
- op=0010011:
  - without the macro → `illegal` pulses in DECODE, next state FETCH, no `RegWrite`.
  - with `MC_CTRL_IMM_EN` → 4 cycles, `ALUSrcB`=01 in EXECUTEI.
